// File: rtl/grant_window_pkg.sv
// Shared types and sizing helpers for the bus-grant acquisition-window controller.
package grant_window_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        OWN     = 2'd2,
        BACKOFF = 2'd3
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 63;

    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/grant_window_cnt.sv
// Window age counter: synchronous clear, enabled increment, sticks at the terminal count.
module grant_window_cnt
    import grant_window_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CW             = cnt_width(TIMEOUT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(TIMEOUT_CYCLES));

    // Holding at the terminal count keeps the counter from ever wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/grant_window_ctrl.sv
// Bus-grant controller: raises grant on req, then reports frame acquisition or
// window timeout, and keeps a saturating count of timeouts.
module grant_window_ctrl
    import grant_window_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned STAT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              frame,
    output logic              grant,
    output logic              aquired,
    output logic              time_out,
    output logic [STAT_W-1:0] to_count
);

    localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

    state_e        state;
    state_e        state_next;
    logic [CW-1:0] cnt;
    logic          cnt_tc;
    logic          cnt_clear;
    logic          cnt_en;

    // Counter sits at zero everywhere outside WAIT, so the first grant cycle sees cnt=0.
    assign cnt_clear = (state != WAIT);
    assign cnt_en    = (state == WAIT);

    grant_window_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CW             (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A claim at cnt==0 is ignored; a claim at the terminal count beats expiry.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req) state_next = WAIT;
            WAIT: begin
                if (frame && (cnt != '0)) begin
                    state_next = OWN;
                end else if (!frame && cnt_tc) begin
                    state_next = BACKOFF;
                end
            end
            OWN:     if (!frame) state_next = IDLE;
            BACKOFF: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        aquired  = 1'b0;
        time_out = 1'b0;
        if (state == WAIT) begin
            aquired  = frame && (cnt != '0);
            time_out = !frame && cnt_tc;
        end
    end

    // Grant is registered from the next state so it tracks WAIT/OWN with no extra lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant <= 1'b0;
        end else begin
            grant <= (state_next == WAIT) || (state_next == OWN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_count <= '0;
        end else if (time_out && (to_count != '1)) begin
            to_count <= to_count + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_grant_window_ctrl.sv
// Directed and randomized bench for grant_window_ctrl against a window-age reference model.
module tb_grant_window_ctrl;

    localparam int unsigned T      = 63;
    localparam int unsigned SW     = 8;
    localparam int unsigned SATMAX = 255;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          frame;
    logic          grant;
    logic          aquired;
    logic          time_out;
    logic [SW-1:0] to_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: grant phase, age of current window, ownership, backoff gap, timeouts.
    bit m_granted;
    bit m_owned;
    bit m_cool;
    int m_age;
    int m_tos;

    grant_window_ctrl #(
        .TIMEOUT_CYCLES (T),
        .STAT_W         (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .frame    (frame),
        .grant    (grant),
        .aquired  (aquired),
        .time_out (time_out),
        .to_count (to_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_granted = 1'b0;
        m_owned   = 1'b0;
        m_cool    = 1'b0;
        m_age     = 0;
        m_tos     = 0;
    endtask

    // One clock cycle: apply inputs, compare this cycle's outputs, then advance the model.
    task automatic tick(input logic r, input logic f);
        bit e_acq;
        bit e_to;
        req   = r;
        frame = f;
        #1;
        e_acq = m_granted && !m_owned && (m_age >= 1) && f;
        e_to  = m_granted && !m_owned && (m_age == T) && !f;
        chk("grant",    {31'd0, grant},    {31'd0, m_granted});
        chk("aquired",  {31'd0, aquired},  {31'd0, e_acq});
        chk("time_out", {31'd0, time_out}, {31'd0, e_to});
        chk("to_count", {24'd0, to_count}, m_tos);
        chk("exclusive", {31'd0, aquired & time_out}, 32'd0);
        @(posedge clk);
        #1;
        if (!m_granted) begin
            if (m_cool) begin
                m_cool = 1'b0;
            end else if (r) begin
                m_granted = 1'b1;
                m_owned   = 1'b0;
                m_age     = 0;
            end
        end else if (m_owned) begin
            if (!f) m_granted = 1'b0;
        end else if (e_acq) begin
            m_owned = 1'b1;
        end else if (e_to) begin
            m_granted = 1'b0;
            m_cool    = 1'b1;
            if (m_tos < SATMAX) m_tos++;
        end else begin
            m_age++;
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        frame = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_grant",    {31'd0, grant},    32'd0);
        chk("reset_to_count", {24'd0, to_count}, 32'd0);
        chk("reset_aquired",  {31'd0, aquired},  32'd0);
        chk("reset_time_out", {31'd0, time_out}, 32'd0);
        rst_n = 1'b1;

        // Plain timeout: req then no frame for the whole window.
        idle_ticks(5);
        tick(1'b1, 1'b0);
        idle_ticks(T + 3);
        chk("t1_count", {24'd0, to_count}, 32'd1);

        // Claim at age 10 held for four cycles.
        tick(1'b1, 1'b0);
        idle_ticks(10);
        repeat (4) tick(1'b0, 1'b1);
        idle_ticks(3);
        chk("t2_count", {24'd0, to_count}, 32'd1);

        // Claim exactly at the terminal count wins over expiry.
        tick(1'b1, 1'b0);
        idle_ticks(T);
        tick(1'b0, 1'b1);
        idle_ticks(3);
        chk("t3_count", {24'd0, to_count}, 32'd1);

        // Frame on the grant-rise cycle is not a claim.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        idle_ticks(T + 2);
        chk("t4_count", {24'd0, to_count}, 32'd2);

        // Asynchronous reset in the middle of an open window.
        tick(1'b1, 1'b0);
        idle_ticks(24);
        rst_n = 1'b0;
        #1;
        chk("async_grant",    {31'd0, grant},    32'd0);
        chk("async_to_count", {24'd0, to_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        idle_ticks(T + 3);
        chk("t5_count", {24'd0, to_count}, 32'd1);

        // Random traffic: frequent claims, then rare claims so timeouts occur.
        for (int i = 0; i < 1500; i++)
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        for (int i = 0; i < 2500; i++)
            tick(($urandom_range(0, 1) == 0), ($urandom_range(0, 127) == 0));

        // Saturation of the timeout statistic.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int w = 0; w < 300; w++) begin
            tick(1'b1, 1'b0);
            idle_ticks(T + 2);
        end
        chk("sat_count", {24'd0, to_count}, SATMAX);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
